// File: rtl/polyveck_pointwise_mont_stream.sv
// polyveck_pointwise_mont_stream
// Loads one NTT-domain polynomial `a` into a local buffer, then streams the K
// polynomials of vector `v` through a two-stage pipeline producing
// r[k][i] = montgomery_reduce(a[i] * v[k][i]) on a valid/ready output stream.
// Optional build macro: POLYVECK_PPM_KEEP_A_EN adds a keep_a input that lets
// a new operation reuse the previously loaded `a` and skip the load phase.
module polyveck_pointwise_mont_stream #(
    parameter int K    = 6,
    parameter int N    = 256,
    parameter int W    = 32,
    parameter int Q    = 8380417,
    parameter int QINV = 58728449
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef POLYVECK_PPM_KEEP_A_EN
    input  logic                  keep_a,
`endif
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic                  a_valid,
    output logic                  a_ready,
    input  logic signed [W-1:0]   a_data,
    input  logic                  v_valid,
    output logic                  v_ready,
    input  logic signed [W-1:0]   v_data,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic signed [W-1:0]   r_data,
    output logic [$clog2(K)-1:0]  r_poly,
    output logic                  r_last
);

    localparam int AW = $clog2(N);
    localparam int KW = $clog2(K);
    localparam logic [AW-1:0]       A_LAST = AW'(N - 1);
    localparam logic [KW-1:0]       K_LAST = KW'(K - 1);
    localparam logic [W-1:0]        QINV_W = W'(QINV);
    localparam logic signed [2*W:0] Q_X    = (2*W+1)'(Q);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD_A = 2'd1,
        S_PROC   = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [AW-1:0]         r_a_cnt;
    logic [AW-1:0]         r_v_cnt;
    logic [KW-1:0]         r_k_cnt;
    logic signed [W-1:0]   r_buf [N];

    logic                  w_en;
    logic                  w_a_hs;
    logic                  w_v_hs;
    logic                  w_pipe_empty;
    logic                  w_keep;
    logic signed [W-1:0]   w_buf_rd;
    logic signed [2*W-1:0] w_a_x;
    logic signed [2*W-1:0] w_v_x;

    logic                  r_vld_p1;
    logic signed [2*W-1:0] r_prod_p1;
    logic [KW-1:0]         r_k_p1;
    logic                  r_last_p1;

    logic                  r_vld_p2;
    logic signed [W-1:0]   r_data_p2;
    logic [KW-1:0]         r_poly_p2;
    logic                  r_last_p2;

    // Montgomery reduction: returns p * 2^-W mod Q, centred in (-Q, Q).
    // t*Q cancels the low W bits of p exactly, so the shift is lossless.
    function automatic logic signed [W-1:0] mont_reduce(input logic signed [2*W-1:0] p);
        logic [W-1:0]        t_u;
        logic signed [2*W:0] t_x;
        logic signed [2*W:0] p_x;
        logic signed [2*W:0] d_x;
        t_u = p[W-1:0] * QINV_W;
        t_x = {{(W+1){t_u[W-1]}}, t_u};
        p_x = {p[2*W-1], p};
        d_x = p_x - t_x * Q_X;
        mont_reduce = d_x[2*W-1:W];
    endfunction

    assign w_en         = !r_vld_p2 || r_ready;
    assign w_a_hs       = a_valid && a_ready;
    assign w_v_hs       = v_valid && v_ready;
    assign w_pipe_empty = !r_vld_p1 && !r_vld_p2;
    assign w_buf_rd     = r_buf[r_v_cnt];
    assign w_a_x        = {{W{w_buf_rd[W-1]}}, w_buf_rd};
    assign w_v_x        = {{W{v_data[W-1]}}, v_data};

`ifdef POLYVECK_PPM_KEEP_A_EN
    logic r_a_loaded;

    // Track whether the buffer holds a complete `a`; a partial load invalidates it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_loaded <= 1'b0;
        end else if (r_state == S_LOAD_A) begin
            r_a_loaded <= w_a_hs && (r_a_cnt == A_LAST);
        end
    end

    assign w_keep = keep_a && r_a_loaded;
`else
    assign w_keep = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake/status outputs.
    always_comb begin
        w_state_nxt = r_state;
        a_ready     = 1'b0;
        v_ready     = 1'b0;
        done        = 1'b0;
        busy        = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = w_keep ? S_PROC : S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                a_ready = 1'b1;
                if (a_valid && (r_a_cnt == A_LAST)) begin
                    w_state_nxt = S_PROC;
                end
            end
            S_PROC: begin
                v_ready = w_en;
                if (v_valid && w_en && (r_k_cnt == K_LAST) && (r_v_cnt == A_LAST)) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    done        = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Load and stream counters; cleared whenever the block is idle.
    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE)) begin
            r_a_cnt <= '0;
            r_v_cnt <= '0;
            r_k_cnt <= '0;
        end else begin
            if (w_a_hs) begin
                r_a_cnt <= (r_a_cnt == A_LAST) ? '0 : r_a_cnt + AW'(1);
            end
            if (w_v_hs) begin
                if (r_v_cnt == A_LAST) begin
                    r_v_cnt <= '0;
                    r_k_cnt <= (r_k_cnt == K_LAST) ? '0 : r_k_cnt + KW'(1);
                end else begin
                    r_v_cnt <= r_v_cnt + AW'(1);
                end
            end
        end
    end

    // Coefficient buffer for `a`; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_a_hs) begin
            r_buf[r_a_cnt] <= a_data;
        end
    end

    // ---- stage 1: full-width product and tags ----
    // Stage 1 valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
        end else if (w_en) begin
            r_vld_p1 <= w_v_hs;
        end
    end

    // Stage 1 data: product of buffered a[i] and incoming v coefficient.
    always_ff @(posedge clk) begin
        if (w_en && w_v_hs) begin
            r_prod_p1 <= w_a_x * w_v_x;
            r_k_p1    <= r_k_cnt;
            r_last_p1 <= (r_v_cnt == A_LAST);
        end
    end

    // ---- stage 2: Montgomery reduction into the output register ----
    // Output register holds while stalled so r_* stay stable until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_poly_p2 <= '0;
            r_last_p2 <= 1'b0;
        end else if (w_en) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= mont_reduce(r_prod_p1);
                r_poly_p2 <= r_k_p1;
                r_last_p2 <= r_last_p1;
            end
        end
    end

    assign r_valid = r_vld_p2;
    assign r_data  = r_data_p2;
    assign r_poly  = r_poly_p2;
    assign r_last  = r_last_p2;

endmodule
